core_inst_seq: RTL and testbench

- Initiator that drives the 17-bit `inst` bus and the `mem_in` data bus into `core`. It is the producer side of the instruction interface that `core` decodes.
- Sequences one full tile: kernel write to kmem, activation write to qmem, kernel load into the mac array, execute, then ofifo drain with SFU results written back to pmem.
- Sits between the testbench/host stream and `core`; replaces hand-written instruction vector files.

---
 rtl/core_inst_seq_pkg.sv | 47 ++++
 rtl/core_inst_seq_if.sv | 30 +++
 rtl/core_inst_seq_delay_line.sv | 29 ++
 rtl/core_inst_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_core_inst_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_inst_seq_pkg.sv
// core_inst_pkg: shared definitions for the core_inst_seq instruction sequencer.
// Holds the inst field bit positions, the sequencer state encoding and a helper
// that normalises the requested activation count.
package core_inst_pkg;

   localparam int INST_W = 17;

   // inst field bit positions
   localparam int OFIFO_RD     = 16;
   localparam int QKMEM_ADD_HI = 15;
   localparam int QKMEM_ADD_LO = 12;
   localparam int PMEM_ADD_HI  = 11;
   localparam int PMEM_ADD_LO  = 8;
   localparam int EXECUTE      = 7;
   localparam int LOAD         = 6;
   localparam int QMEM_RD      = 5;
   localparam int QMEM_WR      = 4;
   localparam int KMEM_RD      = 3;
   localparam int KMEM_WR      = 2;
   localparam int PMEM_RD      = 1;
   localparam int PMEM_WR      = 0;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      KWR  = 3'd1,
      QWR  = 3'd2,
      KLD  = 3'd3,
      GAP  = 3'd4,
      EXE  = 3'd5,
      DRN  = 3'd6,
      FIN  = 3'd7
   } state_t;

   // Zero behaves as one vector; anything above sixteen saturates at sixteen.
   function automatic logic [4:0] clamp_len(input logic [4:0] len_in);
      logic [4:0] res;
      if (len_in == 5'd0) begin
         res = 5'd1;
      end else if (len_in > 5'd16) begin
         res = 5'd16;
      end else begin
         res = len_in;
      end
      return res;
   endfunction

endpackage

// File: rtl/core_inst_seq_if.sv
// core_inst_seq_if: host stream and core-side instruction bus of core_inst_seq.
//   data_in/data_valid/data_ready : host word stream (kernel rows, then activations)
//   fifo_valid                    : ofifo has a complete row
//   inst                          : 17-bit instruction word to core
//   mem_in                        : write data for the q/k memories
// master = sequencer side, slave = host/core side.
interface core_inst_seq_if #(
   parameter int pr = 8,
   parameter int bw = 4
);
   import core_inst_pkg::*;

   logic [pr*bw-1:0]  data_in;
   logic              data_valid;
   logic              data_ready;
   logic              fifo_valid;
   logic [INST_W-1:0] inst;
   logic [pr*bw-1:0]  mem_in;

   modport master (
      input  data_in, data_valid, fifo_valid,
      output data_ready, inst, mem_in
   );

   modport slave (
      output data_in, data_valid, fifo_valid,
      input  data_ready, inst, mem_in
   );

endinterface

// File: rtl/core_inst_seq_delay_line.sv
// inst_delay_line: DEPTH-deep shift register that carries the ofifo_rd pulse
// forward so it reappears as the pmem_wr pulse once SFU output is valid.
//   clk, reset (async active-low), d : pulse in, q : pulse delayed DEPTH cycles
module inst_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr_r;

   // shift the pulse one stage per clock
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_r <= '0;
      end else begin
         sr_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            sr_r[i] <= sr_r[i-1];
         end
      end
   end

   assign q = sr_r[DEPTH-1];

endmodule

// File: rtl/core_inst_seq.sv
// core_inst_seq: sequences one tile into core -- kernel rows to kmem, activations
// to qmem, kernel load into the mac array, execute, then ofifo drain with the
// SFU results written to pmem.
//   clk, reset (async active-low)
//   start : one-cycle tile request (honoured only when idle)
//   len   : activation vector count, sampled on an accepted start
//   busy  : not idle,  done : one-cycle pulse after the last pmem write
//   bus   : host stream + inst/mem_in toward core (master modport)
module core_inst_seq #(
   parameter int col     = 8,
   parameter int bw      = 4,
   parameter int pr      = 8,
   parameter int SFP_LAT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] len,
   output logic       busy,
   output logic       done,
   core_inst_seq_if.master bus
);
   import core_inst_pkg::*;

   localparam logic [4:0] COL_LAST = 5'(col - 1);

   state_t           state_r, state_s;
   logic [4:0]       len_r, len_s;
   logic [4:0]       cnt_r, cnt_s;
   logic [4:0]       rd_cnt_r, rd_cnt_s;
   logic [4:0]       wr_cnt_r, wr_cnt_s;
   logic [3:0]       qkmem_add_r, qkmem_add_s;
   logic [pr*bw-1:0] mem_in_r, mem_in_s;
   logic             ofifo_rd_r, ofifo_rd_s;
   logic             kmem_wr_r, kmem_wr_s;
   logic             kmem_rd_r, kmem_rd_s;
   logic             qmem_wr_r, qmem_wr_s;
   logic             qmem_rd_r, qmem_rd_s;
   logic             load_r, execute_r;
   logic             data_ready_r, busy_r, done_r;
   logic             accept_s, wr_pulse_s;
   logic [INST_W-1:0] inst_s;

   assign accept_s = bus.data_valid & data_ready_r;

   inst_delay_line #(.DEPTH(SFP_LAT)) u_pmem_dly (
      .clk   (clk),
      .reset (reset),
      .d     (ofifo_rd_r),
      .q     (wr_pulse_s)
   );

   // next-state and next-output logic
   always_comb begin
      state_s     = state_r;
      len_s       = len_r;
      cnt_s       = cnt_r;
      rd_cnt_s    = rd_cnt_r;
      wr_cnt_s    = wr_cnt_r;
      qkmem_add_s = qkmem_add_r;
      mem_in_s    = mem_in_r;
      ofifo_rd_s  = 1'b0;
      kmem_wr_s   = 1'b0;
      kmem_rd_s   = 1'b0;
      qmem_wr_s   = 1'b0;
      qmem_rd_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               len_s    = clamp_len(len);
               cnt_s    = 5'd0;
               rd_cnt_s = 5'd0;
               wr_cnt_s = 5'd0;
               state_s  = KWR;
            end else begin
               state_s  = IDLE;
            end
         end
         KWR: begin
            if (accept_s) begin
               kmem_wr_s   = 1'b1;
               qkmem_add_s = cnt_r[3:0];
               mem_in_s    = bus.data_in;
               if (cnt_r == COL_LAST) begin
                  cnt_s   = 5'd0;
                  state_s = QWR;
               end else begin
                  cnt_s   = cnt_r + 5'd1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         QWR: begin
            if (accept_s) begin
               qmem_wr_s   = 1'b1;
               qkmem_add_s = cnt_r[3:0];
               mem_in_s    = bus.data_in;
               if (cnt_r == len_r - 5'd1) begin
                  cnt_s   = 5'd0;
                  state_s = KLD;
               end else begin
                  cnt_s   = cnt_r + 5'd1;
               end
            end else begin
               cnt_s = cnt_r;
            end
         end
         KLD: begin
            kmem_rd_s   = 1'b1;
            qkmem_add_s = cnt_r[3:0];
            if (cnt_r == COL_LAST) begin
               cnt_s   = 5'd0;
               state_s = GAP;
            end else begin
               cnt_s   = cnt_r + 5'd1;
            end
         end
         // Two state cycles: the first carries the trailing load, the second
         // leaves inst[7:0] all-zero so mac_in switches to qmem before execute.
         GAP: begin
            if (cnt_r == 5'd1) begin
               cnt_s   = 5'd0;
               state_s = EXE;
            end else begin
               cnt_s   = cnt_r + 5'd1;
            end
         end
         EXE: begin
            qmem_rd_s   = 1'b1;
            qkmem_add_s = cnt_r[3:0];
            if (cnt_r == len_r - 5'd1) begin
               cnt_s   = 5'd0;
               state_s = DRN;
            end else begin
               cnt_s   = cnt_r + 5'd1;
            end
         end
         DRN: begin
            if (bus.fifo_valid && (rd_cnt_r < len_r)) begin
               ofifo_rd_s = 1'b1;
               rd_cnt_s   = rd_cnt_r + 5'd1;
            end else begin
               rd_cnt_s   = rd_cnt_r;
            end
            // wr_cnt doubles as pmem_add, so it advances after each write.
            if (wr_pulse_s) begin
               wr_cnt_s = wr_cnt_r + 5'd1;
               if (wr_cnt_r == len_r - 5'd1) begin
                  state_s = FIN;
               end else begin
                  state_s = DRN;
               end
            end else begin
               wr_cnt_s = wr_cnt_r;
            end
         end
         FIN: begin
            wr_cnt_s = 5'd0;
            state_s  = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         len_r        <= 5'd0;
         cnt_r        <= 5'd0;
         rd_cnt_r     <= 5'd0;
         wr_cnt_r     <= 5'd0;
         qkmem_add_r  <= 4'd0;
         mem_in_r     <= '0;
         ofifo_rd_r   <= 1'b0;
         kmem_wr_r    <= 1'b0;
         kmem_rd_r    <= 1'b0;
         qmem_wr_r    <= 1'b0;
         qmem_rd_r    <= 1'b0;
         load_r       <= 1'b0;
         execute_r    <= 1'b0;
         data_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         len_r        <= len_s;
         cnt_r        <= cnt_s;
         rd_cnt_r     <= rd_cnt_s;
         wr_cnt_r     <= wr_cnt_s;
         qkmem_add_r  <= qkmem_add_s;
         mem_in_r     <= mem_in_s;
         ofifo_rd_r   <= ofifo_rd_s;
         kmem_wr_r    <= kmem_wr_s;
         kmem_rd_r    <= kmem_rd_s;
         qmem_wr_r    <= qmem_wr_s;
         qmem_rd_r    <= qmem_rd_s;
         // memory Q arrives one cycle after the read, so load/execute trail it
         load_r       <= kmem_rd_r;
         execute_r    <= qmem_rd_r;
         data_ready_r <= (state_s == KWR) || (state_s == QWR);
         busy_r       <= (state_s != IDLE);
         done_r       <= (state_s == FIN);
      end
   end

   // assemble the instruction word from its field registers
   always_comb begin
      inst_s                           = '0;
      inst_s[OFIFO_RD]                 = ofifo_rd_r;
      inst_s[QKMEM_ADD_HI:QKMEM_ADD_LO] = qkmem_add_r;
      inst_s[PMEM_ADD_HI:PMEM_ADD_LO]   = wr_cnt_r[3:0];
      inst_s[EXECUTE]                  = execute_r;
      inst_s[LOAD]                     = load_r;
      inst_s[QMEM_RD]                  = qmem_rd_r;
      inst_s[QMEM_WR]                  = qmem_wr_r;
      inst_s[KMEM_RD]                  = kmem_rd_r;
      inst_s[KMEM_WR]                  = kmem_wr_r;
      inst_s[PMEM_RD]                  = 1'b0;
      inst_s[PMEM_WR]                  = wr_pulse_s;
   end

   assign bus.inst       = inst_s;
   assign bus.mem_in     = mem_in_r;
   assign bus.data_ready = data_ready_r;
   assign busy           = busy_r;
   assign done           = done_r;

endmodule

// File: tb/tb_core_inst_seq.sv
// Testbench for core_inst_seq: per-tile expected traces are built from the
// tile's input patterns (accept cycles, phase lengths, drain pattern), then the
// tile is replayed cycle by cycle and every output compared.
module tb_core_inst_seq;

   localparam int COL  = 8;
   localparam int BW   = 4;
   localparam int PR   = 8;
   localparam int LAT  = 1;
   localparam int DW   = PR * BW;
   localparam int MAXC = 512;

   localparam int B_OFIFO = 16;
   localparam int B_EXE   = 7;
   localparam int B_LOAD  = 6;
   localparam int B_QRD   = 5;
   localparam int B_QWR   = 4;
   localparam int B_KRD   = 3;
   localparam int B_KWR   = 2;
   localparam int B_PWR   = 0;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [4:0] len;
   logic       busy;
   logic       done;

   core_inst_seq_if #(.pr(PR), .bw(BW)) bus ();

   core_inst_seq #(.col(COL), .bw(BW), .pr(PR), .SFP_LAT(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .len   (len),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   // expected trace and stimulus for one tile, indexed by cycle (0 = start cycle)
   logic [16:0]   e_inst [MAXC];
   logic          e_qk   [MAXC];
   logic          e_pw   [MAXC];
   logic          e_wr   [MAXC];
   logic [DW-1:0] e_mem  [MAXC];
   logic          e_rdy  [MAXC];
   logic          e_busy [MAXC];
   logic          e_done [MAXC];
   logic          dv     [MAXC];
   logic          fv     [MAXC];
   logic [DW-1:0] din    [MAXC];
   int            acc_cyc[32];

   task automatic run_tile(input int len_in, input int dv_mode, input int fv_mode);
      int L, acc, k, c_last, kr0, qr0, d0, rd, last_wr, n_cyc;
      logic [4:0]  pat;
      logic [16:0] mask;
      pat     = 5'b11011;
      last_wr = 0;
      L = (len_in == 0) ? 1 : ((len_in > 16) ? 16 : len_in);
      for (int i = 0; i < MAXC; i++) begin
         e_inst[i] = '0; e_qk[i] = 1'b0; e_pw[i] = 1'b0; e_wr[i] = 1'b0;
         e_mem[i] = '0; e_rdy[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
         dv[i]  = (dv_mode == 0 || i > 120) ? 1'b1 :
                  (dv_mode == 1) ? ((i % 2) == 1) : 1'($urandom_range(0, 1));
         din[i] = DW'($urandom);
         fv[i]  = 1'($urandom_range(0, 1));
      end
      // host stream: the first COL accepted words are kernel rows, the next L activations
      acc = 0;
      k   = 1;
      while (acc < COL + L) begin
         if (dv[k]) begin
            acc_cyc[acc] = k;
            acc++;
         end
         k++;
      end
      c_last = acc_cyc[COL+L-1];
      for (int t = 1; t <= c_last; t++) e_rdy[t] = 1'b1;
      for (int a = 0; a < COL + L; a++) begin
         k = acc_cyc[a] + 1;
         e_wr[k]  = 1'b1;
         e_qk[k]  = 1'b1;
         e_mem[k] = din[acc_cyc[a]];
         if (a < COL) begin
            e_inst[k][B_KWR]  = 1'b1;
            e_inst[k][15:12]  = 4'(a);
         end else begin
            e_inst[k][B_QWR]  = 1'b1;
            e_inst[k][15:12]  = 4'(a - COL);
         end
      end
      // kernel load, one all-zero gap cycle, then execute
      kr0 = c_last + 2;
      for (int i = 0; i < COL; i++) begin
         e_inst[kr0+i][B_KRD]    = 1'b1;
         e_inst[kr0+i][15:12]    = 4'(i);
         e_qk[kr0+i]             = 1'b1;
         e_inst[kr0+i+1][B_LOAD] = 1'b1;
      end
      qr0 = kr0 + COL + 2;
      for (int j = 0; j < L; j++) begin
         e_inst[qr0+j][B_QRD]   = 1'b1;
         e_inst[qr0+j][15:12]   = 4'(j);
         e_qk[qr0+j]            = 1'b1;
         e_inst[qr0+j+1][B_EXE] = 1'b1;
      end
      // drain: fifo_valid is honoured from the cycle after the last qmem_rd request
      d0 = qr0 + L - 1;
      for (int i = d0; i < MAXC; i++) begin
         if (fv_mode == 0 || i > 300) fv[i] = 1'b1;
         else if (fv_mode == 1)       fv[i] = pat[(i - d0) % 5];
      end
      rd = 0;
      k  = d0;
      while (rd < L) begin
         if (fv[k]) begin
            e_inst[k+1][B_OFIFO]     = 1'b1;
            e_inst[k+1+LAT][B_PWR]   = 1'b1;
            e_inst[k+1+LAT][11:8]    = 4'(rd);
            e_pw[k+1+LAT]            = 1'b1;
            last_wr                  = k + 1 + LAT;
            rd++;
         end
         k++;
      end
      e_done[last_wr+1] = 1'b1;
      for (int t = 1; t <= last_wr + 1; t++) e_busy[t] = 1'b1;
      n_cyc = last_wr + 4;

      for (int t = 0; t < n_cyc; t++) begin
         @(posedge clk);
         #1;
         cyc   = t;
         // stray starts while busy must be ignored
         start = (t == 0) ? 1'b1 : ((t <= last_wr + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
         len   = (t == 0) ? 5'(len_in) : 5'($urandom);
         bus.data_valid = dv[t];
         bus.data_in    = din[t];
         bus.fifo_valid = fv[t];
         @(negedge clk);
         mask = 17'h1ffff;
         if (!e_qk[t]) mask[15:12] = 4'd0;
         if (!e_pw[t]) mask[11:8]  = 4'd0;
         check_eq("inst", 64'(bus.inst & mask), 64'(e_inst[t] & mask));
         check_eq("busy_done_ready", 64'({busy, done, bus.data_ready}),
                  64'({e_busy[t], e_done[t], e_rdy[t]}));
         if (e_wr[t]) check_eq("mem_in", 64'(bus.mem_in), 64'(e_mem[t]));
      end
      start = 1'b0;
   endtask

   // abort a tile after three kernel accepts with an asynchronous reset
   task automatic reset_mid_kwr();
      @(posedge clk); #1;
      start = 1'b1; len = 5'd4;
      bus.data_valid = 1'b1; bus.data_in = 32'hA5A5_5A5A; bus.fifo_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(posedge clk); #1;
      cyc = -1;
      check_eq("pre_rst_kwr", 64'({bus.inst[15:12], bus.inst[B_KWR]}), 64'({4'd2, 1'b1}));
      #2;
      reset = 1'b0;
      #1;
      check_eq("rst_inst", 64'(bus.inst), 64'd0);
      check_eq("rst_mem_in", 64'(bus.mem_in), 64'd0);
      check_eq("rst_busy_done_ready", 64'({busy, done, bus.data_ready}), 64'd0);
      bus.data_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      len   = 5'd0;
      bus.data_valid = 1'b0;
      bus.data_in    = '0;
      bus.fifo_valid = 1'b0;
      #1;
      check_eq("reset_inst", 64'(bus.inst), 64'd0);
      check_eq("reset_status", 64'({busy, done, bus.data_ready, bus.mem_in}), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_tile(4, 0, 0);       // steady stream, steady fifo
      run_tile(4, 1, 1);       // bubbles in the stream, fifo pattern 1,1,0,1,1
      reset_mid_kwr();
      run_tile(4, 0, 0);       // after abort, kmem restarts at address 0
      run_tile(0, 2, 2);       // len 0 behaves as 1
      run_tile(20, 2, 2);      // len 20 clamps to 16
      run_tile(16, 1, 1);
      for (int n = 0; n < 6; n++) begin
         run_tile(int'($urandom_range(0, 31)), 2, 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
